// File: rtl/adaptor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adaptor_pkg
//  Description : Shared types and constants for the cache-line adaptor.
//                Holds the burst FSM state encoding and the default line
//                geometry: 4 beats of 64 bits each, giving a 256-bit line
//                with a 5-bit byte offset.
//  Revision    : 1.0 - initial release
// ============================================================================
package adaptor_pkg;

    localparam int BEATS       = 4;
    localparam int BEAT_W      = 64;
    localparam int LINE_W      = BEATS * BEAT_W;
    localparam int ADDR_W      = 32;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Clears the byte-offset bits so the memory side only ever sees a
    // line-aligned address.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] mask;
        mask = ~((ADDR_W'(1) << OFFSET_BITS) - ADDR_W'(1));
        return addr & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cacheline_adaptor_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : beat_counter
//  Description : Small up-counter with synchronous clear and enable, plus a
//                terminal-count flag that is high while the count equals
//                LAST. Used for the burst beat index and for the idle-cycle
//                watchdog.
//  Ports       : clk   - clock, rising edge
//                rst   - asynchronous active-high reset
//                clr   - synchronous clear (has priority over en)
//                en    - increment enable
//                count - current count
//                tc    - count == LAST
//  Revision    : 1.0 - initial release
// ============================================================================
module beat_counter #(
    parameter int WIDTH = 2,
    parameter int LAST  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == WIDTH'(LAST));

endmodule
`default_nettype wire

// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : cacheline_adaptor
//  Description : Turns one 256-bit cache-line fill or write-back into a
//                BEATS-beat burst of BEAT_W-bit words on the memory bus.
//                One transaction at a time; read wins when both requests
//                are seen together in IDLE.
//  Macro       : ADAPTOR_TIMEOUT_EN - enables the idle-beat watchdog that
//                aborts a burst after TIMEOUT consecutive cycles without
//                resp_i and reports it on err_o. Undefined: waits forever,
//                err_o is tied low.
//  Ports       : clk, rst            - clock / async active-high reset
//                line_i / line_o     - write-back line in / fill line out
//                address_i           - line address from cache
//                read_i / write_i    - cache fill / write-back requests
//                resp_o              - one-cycle completion pulse to cache
//                burst_i / burst_o   - read beat in / write beat out
//                address_o           - line-aligned address to memory
//                read_o / write_o    - memory burst requests
//                resp_i              - memory beat valid / accept
//                err_o               - one-cycle abort pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adaptor #(
    parameter int BEATS   = adaptor_pkg::BEATS,
    parameter int BEAT_W  = adaptor_pkg::BEAT_W,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BEATS*BEAT_W-1:0] line_i,
    output logic [BEATS*BEAT_W-1:0] line_o,
    input  logic [31:0]             address_i,
    input  logic                    read_i,
    input  logic                    write_i,
    output logic                    resp_o,
    input  logic [BEAT_W-1:0]       burst_i,
    output logic [BEAT_W-1:0]       burst_o,
    output logic [31:0]             address_o,
    output logic                    read_o,
    output logic                    write_o,
    input  logic                    resp_i,
    output logic                    err_o
);

    import adaptor_pkg::*;

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t                    state;
    state_t                    state_nx;
    logic [CNT_W-1:0]          cnt;
    logic                      cnt_tc;
    logic                      cnt_clr;
    logic                      cnt_en;
    logic [31:0]               addr_q;
    logic [BEATS*BEAT_W-1:0]   wline_q;
    logic                      in_burst;
    logic                      abort;

    assign in_burst = (state == RD_BURST) || (state == WR_BURST);

    // ------------------------------------------------------------------
    // Beat index: cleared when a burst starts and again on its last beat,
    // so it never wraps inside a transaction.
    // ------------------------------------------------------------------
    beat_counter #(
        .WIDTH (CNT_W),
        .LAST  (BEATS - 1)
    ) u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt),
        .tc    (cnt_tc)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs. Outputs depend on state only, so
    // an async reset clears them in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        read_o   = 1'b0;
        write_o  = 1'b0;
        resp_o   = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;

        case (state)
            IDLE: begin
                if (read_i) begin
                    state_nx = RD_BURST;
                    cnt_clr  = 1'b1;
                end else if (write_i) begin
                    state_nx = WR_BURST;
                    cnt_clr  = 1'b1;
                end
            end

            RD_BURST, WR_BURST: begin
                read_o  = (state == RD_BURST);
                write_o = (state == WR_BURST);
                if (resp_i) begin
                    if (cnt_tc) begin
                        state_nx = DONE;
                        cnt_clr  = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end else if (abort) begin
                    state_nx = DONE;
                    cnt_clr  = 1'b1;
                end
            end

            DONE: begin
                resp_o   = 1'b1;
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request capture in IDLE and fill-beat assembly.
    // line_o is written beat-by-beat in place, so a partial or aborted
    // fill leaves older beats untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wline_q <= '0;
            line_o  <= '0;
        end else begin
            if (state == IDLE) begin
                if (read_i) begin
                    addr_q <= line_align(address_i);
                end else if (write_i) begin
                    addr_q  <= line_align(address_i);
                    wline_q <= line_i;
                end
            end
            if ((state == RD_BURST) && resp_i) begin
                line_o[cnt*BEAT_W +: BEAT_W] <= burst_i;
            end
        end
    end

    assign address_o = addr_q;
    assign burst_o   = (state == WR_BURST) ? wline_q[cnt*BEAT_W +: BEAT_W] : '0;

    // ------------------------------------------------------------------
    // Optional idle-beat watchdog
    // ------------------------------------------------------------------
`ifdef ADAPTOR_TIMEOUT_EN
    localparam int WD_W = 8;

    logic [WD_W-1:0] unused_wd_count;
    logic            wd_tc;
    logic            wd_en;
    logic            wd_clr;
    logic            timed_out;

    // Counts consecutive stalled burst cycles; any beat or leaving the
    // burst restarts it. Firing on the TIMEOUT-th stalled cycle sends the
    // FSM to DONE instead of waiting for another beat.
    assign wd_en  = in_burst && !resp_i;
    assign wd_clr = !in_burst || resp_i;

    beat_counter #(
        .WIDTH (WD_W),
        .LAST  (TIMEOUT - 1)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (wd_clr),
        .en    (wd_en),
        .count (unused_wd_count),
        .tc    (wd_tc)
    );

    assign abort = wd_en && wd_tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timed_out <= 1'b0;
        end else if (abort) begin
            timed_out <= 1'b1;
        end else if (state == IDLE) begin
            timed_out <= 1'b0;
        end
    end

    assign err_o = (state == DONE) && timed_out;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0) && in_burst;
    assign abort          = 1'b0;
    assign err_o          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cacheline_adaptor
//  Description : Directed self-checking bench for cacheline_adaptor.
//                Watchdog scenario is built only with ADAPTOR_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [255:0] line_i = '0;
    logic [255:0] line_o;
    logic [31:0]  address_i = '0;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic         resp_o;
    logic [63:0]  burst_i = '0;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i = 1'b0;
    logic         err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cacheline_adaptor #(
        .BEATS   (4),
        .BEAT_W  (64),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i),
        .err_o     (err_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        checks++; if (line_o !== 256'h0) begin failures++; $display("FAIL reset_line_o got=%h exp=0", line_o); end
        checks++; if (address_o !== 32'h0) begin failures++; $display("FAIL reset_address_o got=%h exp=0", address_o); end
        checks++; if (burst_o !== 64'h0) begin failures++; $display("FAIL reset_burst_o got=%h exp=0", burst_o); end
        checks++; if ({read_o, write_o, resp_o, err_o} !== 4'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0000", {read_o, write_o, resp_o, err_o}); end
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_fill;
        logic [63:0]  b [4];
        logic [255:0] exp_line;
        b[0] = 64'h1111_1111_1111_1111;
        b[1] = 64'h2222_2222_2222_2222;
        b[2] = 64'h3333_3333_3333_3333;
        b[3] = 64'h4444_4444_4444_4444;
        exp_line = {b[3], b[2], b[1], b[0]};
        address_i = 32'h0000_1234;
        read_i    = 1'b1;
        tick;
        read_i = 1'b0;
        checks++; if (address_o !== 32'h0000_1220) begin failures++; $display("FAIL fill_address_o got=%h exp=00001220", address_o); end
        for (int i = 0; i < 4; i++) begin
            checks++; if ({read_o, write_o, resp_o} !== 3'b100) begin failures++; $display("FAIL fill_beat%0d_ctrl got=%b exp=100", i, {read_o, write_o, resp_o}); end
            resp_i  = 1'b1;
            burst_i = b[i];
            tick;
        end
        resp_i = 1'b0;
        checks++; if (resp_o !== 1'b1) begin failures++; $display("FAIL fill_resp_o got=%b exp=1", resp_o); end
        checks++; if (read_o !== 1'b0) begin failures++; $display("FAIL fill_read_drop got=%b exp=0", read_o); end
        checks++; if (line_o !== exp_line) begin failures++; $display("FAIL fill_line_o got=%h exp=%h", line_o, exp_line); end
        checks++; if (address_o !== 32'h0000_1220) begin failures++; $display("FAIL fill_address_hold got=%h exp=00001220", address_o); end
        tick;
        checks++; if (resp_o !== 1'b0) begin failures++; $display("FAIL fill_resp_single got=%b exp=0", resp_o); end
        checks++; if (line_o !== exp_line) begin failures++; $display("FAIL fill_line_hold got=%h exp=%h", line_o, exp_line); end
    endtask

    task automatic test_writeback;
        logic [63:0] b [4];
        logic        pat [6];
        int          idx;
        int          resp_seen;
        b[0] = {8{8'hA0}};
        b[1] = {8{8'hA1}};
        b[2] = {8{8'hA2}};
        b[3] = {8{8'hA3}};
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
        pat[3] = 1'b1; pat[4] = 1'b1; pat[5] = 1'b1;
        line_i    = {b[3], b[2], b[1], b[0]};
        address_i = 32'h0000_ABCD;
        write_i   = 1'b1;
        tick;
        write_i = 1'b0;
        line_i  = '0;
        checks++; if (address_o !== 32'h0000_ABC0) begin failures++; $display("FAIL wb_address_o got=%h exp=0000abc0", address_o); end
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            checks++; if ({read_o, write_o, resp_o} !== 3'b010) begin failures++; $display("FAIL wb_cyc%0d_ctrl got=%b exp=010", i, {read_o, write_o, resp_o}); end
            checks++; if (burst_o !== b[idx]) begin failures++; $display("FAIL wb_cyc%0d_burst_o got=%h exp=%h", i, burst_o, b[idx]); end
            resp_i = pat[i];
            tick;
            if (pat[i]) idx++;
        end
        resp_i = 1'b0;
        checks++; if ({write_o, resp_o} !== 2'b01) begin failures++; $display("FAIL wb_done got=%b exp=01", {write_o, resp_o}); end
        resp_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (resp_o === 1'b1) resp_seen++;
        end
        checks++; if (resp_seen != 0) begin failures++; $display("FAIL wb_resp_single got=%0d extra exp=0", resp_seen); end
    endtask

    task automatic test_read_priority;
        logic [63:0]  b [4];
        logic [255:0] old_line;
        old_line = {4{64'h4444_4444_4444_4444}};
        old_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        b[0] = 64'h0123_4567_89AB_CDEF;
        b[1] = 64'hFEDC_BA98_7654_3210;
        b[2] = 64'h5555_AAAA_5555_AAAA;
        b[3] = 64'hDEAD_BEEF_CAFE_F00D;
        address_i = 32'h1000_003F;
        line_i    = {4{64'hFFFF_FFFF_FFFF_FFFF}};
        read_i    = 1'b1;
        write_i   = 1'b1;
        tick;
        read_i  = 1'b0;
        write_i = 1'b0;
        checks++; if ({read_o, write_o} !== 2'b10) begin failures++; $display("FAIL both_ctrl got=%b exp=10", {read_o, write_o}); end
        checks++; if (address_o !== 32'h1000_0020) begin failures++; $display("FAIL both_address_o got=%h exp=10000020", address_o); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (write_o !== 1'b0) begin failures++; $display("FAIL both_beat%0d_write_o got=%b exp=0", i, write_o); end
            resp_i  = 1'b1;
            burst_i = b[i];
            tick;
            if (i == 0) begin
                checks++; if (line_o !== {old_line[255:64], b[0]}) begin failures++; $display("FAIL both_partial_line got=%h exp=%h", line_o, {old_line[255:64], b[0]}); end
            end
        end
        resp_i = 1'b0;
        checks++; if (resp_o !== 1'b1) begin failures++; $display("FAIL both_resp_o got=%b exp=1", resp_o); end
        checks++; if (line_o !== {b[3], b[2], b[1], b[0]}) begin failures++; $display("FAIL both_line_o got=%h exp=%h", line_o, {b[3], b[2], b[1], b[0]}); end
        tick;
    endtask

    task automatic test_reset_mid_burst;
        logic [63:0] b [4];
        b[0] = 64'h0A0A_0A0A_0A0A_0A0A;
        b[1] = 64'h0B0B_0B0B_0B0B_0B0B;
        b[2] = 64'h0C0C_0C0C_0C0C_0C0C;
        b[3] = 64'h0D0D_0D0D_0D0D_0D0D;
        address_i = 32'h2000_0044;
        read_i    = 1'b1;
        tick;
        read_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            resp_i  = 1'b1;
            burst_i = 64'h9999_9999_9999_9999;
            tick;
        end
        resp_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (line_o !== 256'h0) begin failures++; $display("FAIL rstmid_line_o got=%h exp=0", line_o); end
        checks++; if (address_o !== 32'h0) begin failures++; $display("FAIL rstmid_address_o got=%h exp=0", address_o); end
        checks++; if ({read_o, write_o, resp_o, err_o, burst_o} !== 68'h0) begin failures++; $display("FAIL rstmid_ctrl got=%b%b%b%b exp=0000", read_o, write_o, resp_o, err_o); end
        #1;
        rst       = 1'b0;
        address_i = 32'h8000_0040;
        read_i    = 1'b1;
        tick;
        read_i = 1'b0;
        checks++; if ({read_o, resp_o} !== 2'b10) begin failures++; $display("FAIL rstmid_restart got=%b exp=10", {read_o, resp_o}); end
        checks++; if (address_o !== 32'h8000_0040) begin failures++; $display("FAIL rstmid_address2 got=%h exp=80000040", address_o); end
        for (int i = 0; i < 4; i++) begin
            resp_i  = 1'b1;
            burst_i = b[i];
            tick;
        end
        resp_i = 1'b0;
        checks++; if (resp_o !== 1'b1) begin failures++; $display("FAIL rstmid_resp_o got=%b exp=1", resp_o); end
        checks++; if (line_o !== {b[3], b[2], b[1], b[0]}) begin failures++; $display("FAIL rstmid_line2 got=%h exp=%h", line_o, {b[3], b[2], b[1], b[0]}); end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [63:0] b [4];
        int          resp_seen;
        b[0] = 64'h1000_0000_0000_0001;
        b[1] = 64'h2000_0000_0000_0002;
        b[2] = 64'h3000_0000_0000_0003;
        b[3] = 64'h4000_0000_0000_0004;
        address_i = 32'h0000_0100;
        read_i    = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            resp_i  = 1'b1;
            burst_i = b[i];
            tick;
        end
        resp_i = 1'b0;
        checks++; if (resp_o !== 1'b1) begin failures++; $display("FAIL b2b_first_resp got=%b exp=1", resp_o); end
        tick;
        checks++; if ({read_o, resp_o} !== 2'b00) begin failures++; $display("FAIL b2b_idle got=%b exp=00", {read_o, resp_o}); end
        address_i = 32'h0000_0200;
        tick;
        read_i = 1'b0;
        checks++; if (read_o !== 1'b1) begin failures++; $display("FAIL b2b_second_start got=%b exp=1", read_o); end
        checks++; if (address_o !== 32'h0000_0200) begin failures++; $display("FAIL b2b_address2 got=%h exp=00000200", address_o); end
        resp_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_o === 1'b1) resp_seen++;
            resp_i  = 1'b1;
            burst_i = ~b[i];
            tick;
        end
        resp_i = 1'b0;
        checks++; if (resp_seen != 0) begin failures++; $display("FAIL b2b_dup_resp got=%0d exp=0", resp_seen); end
        checks++; if (resp_o !== 1'b1) begin failures++; $display("FAIL b2b_second_resp got=%b exp=1", resp_o); end
        checks++; if (line_o !== ~{b[3], b[2], b[1], b[0]}) begin failures++; $display("FAIL b2b_line2 got=%h exp=%h", line_o, ~{b[3], b[2], b[1], b[0]}); end
        tick;
    endtask

`ifdef ADAPTOR_TIMEOUT_EN
    task automatic test_timeout;
        address_i = 32'h0000_0300;
        read_i    = 1'b1;
        tick;
        read_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            checks++; if ({read_o, resp_o, err_o} !== 3'b100) begin failures++; $display("FAIL to_cyc%0d got=%b exp=100", i, {read_o, resp_o, err_o}); end
            tick;
        end
        checks++; if ({read_o, resp_o, err_o} !== 3'b011) begin failures++; $display("FAIL to_abort got=%b exp=011", {read_o, resp_o, err_o}); end
        tick;
        checks++; if ({read_o, resp_o, err_o} !== 3'b000) begin failures++; $display("FAIL to_after got=%b exp=000", {read_o, resp_o, err_o}); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_writeback();
        test_read_priority();
        test_reset_mid_burst();
        test_back_to_back();
`ifdef ADAPTOR_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
